// File: rtl/block_dram_if.sv
// Request/response bundle between the data cache (master) and the block DRAM
// model (slave).
interface block_dram_if #(
  parameter int ADDR_W = 10
);
  logic              re;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [1:0]        offset;
  logic [31:0]       din;
  logic [127:0]      dout;
  logic              complete;
  logic              busy;

  modport master (
    output re, we, addr, offset, din,
    input  dout, complete, busy
  );

  modport slave (
    input  re, we, addr, offset, din,
    output dout, complete, busy
  );
endinterface

// File: rtl/block_dram.sv
// Fixed-latency 128-bit block memory behind the data cache: block reads,
// single-word writes, one-cycle complete pulse after LATENCY cycles.
module block_dram #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 20
) (
  input logic        clk,
  input logic        rst,
  block_dram_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

  state_e            state_q;
  logic              op_rd_q;
  logic              op_wr_q;
  logic [ADDR_W-1:0] a_q;
  logic [1:0]        off_q;
  logic [31:0]       din_q;
  logic [7:0]        cnt_q;
  logic              complete_q;
  logic              busy_q;
  logic [127:0]      dout_q;

  logic              access;
  logic [ADDR_W-1:0] rd_addr;
  logic [127:0]      blk_d;

  assign access = (state_q == S_BUSY) && (cnt_q == 8'd0);

  // The read port follows the live address while idle so the block is already
  // registered by the time a LATENCY=1 access completes.
  assign rd_addr = (state_q == S_IDLE) ? bus.addr : a_q;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_bank
      logic [31:0] bank_q [DEPTH];
      logic [31:0] rd_q;
      logic        sel;

      assign sel = op_wr_q && (off_q == 2'(gi));

      always_ff @(posedge clk) begin
        if (access && sel) begin
          bank_q[a_q] <= din_q;
        end
        rd_q <= bank_q[rd_addr];
      end

      // Merged view: a combined read+write returns the block after the write.
      assign blk_d[32*gi +: 32] = sel ? din_q : rd_q;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      op_rd_q    <= 1'b0;
      op_wr_q    <= 1'b0;
      a_q        <= '0;
      off_q      <= 2'd0;
      din_q      <= 32'd0;
      cnt_q      <= 8'd0;
      complete_q <= 1'b0;
      busy_q     <= 1'b0;
      dout_q     <= 128'd0;
    end else begin
      complete_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.re || bus.we) begin
            op_rd_q <= bus.re;
            op_wr_q <= bus.we;
            a_q     <= bus.addr;
            off_q   <= bus.offset;
            din_q   <= bus.din;
            cnt_q   <= 8'(LATENCY - 1);
            busy_q  <= 1'b1;
            state_q <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (cnt_q != 8'd0) begin
            cnt_q <= cnt_q - 8'd1;
          end else begin
            if (op_rd_q) begin
              dout_q <= blk_d;
            end
            complete_q <= 1'b1;
            state_q    <= S_DONE;
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.dout     = dout_q;
  assign bus.complete = complete_q;
  assign bus.busy     = busy_q;
endmodule

// File: tb/tb_block_dram.sv
// Self-checking bench for block_dram: directed vector table, hand sequences
// for reset/ignored-request corners, and randomized traffic against a model.
module tb_block_dram;
  localparam int ADDR_W  = 10;
  localparam int LATENCY = 20;
  localparam int TOP     = (1 << ADDR_W) - 1;

  logic clk;
  logic rst;

  block_dram_if #(.ADDR_W(ADDR_W)) bus ();

  block_dram #(.ADDR_W(ADDR_W), .LATENCY(LATENCY)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic              re;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [1:0]        off;
    logic [31:0]       din;
    logic [127:0]      exp_dout;
  } vec_t;

  vec_t         vecs [15];
  logic [127:0] mdl [1 << ADDR_W];
  logic [127:0] last_dout;
  int           n_checks = 0;
  int           n_pass   = 0;
  int           txn      = 0;
  int           addr_set [8] = '{0, 1, 3, 5, 7, 100, 512, TOP};

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // One complete transaction: present, accept, wait for the pulse, confirm it is single.
  task automatic access(input logic r, input logic w, input logic [ADDR_W-1:0] a,
                        input logic [1:0] o, input logic [31:0] d, output logic [127:0] got);
    int lat;
    @(negedge clk);
    bus.re = r; bus.we = w; bus.addr = a; bus.offset = o; bus.din = d;
    @(posedge clk); #1;
    bus.re = 1'b0; bus.we = 1'b0;
    check($sformatf("txn%0d busy_after_accept", txn), 128'(bus.busy), 128'd1);
    lat = -1;
    for (int k = 1; k <= 300; k++) begin
      @(posedge clk); #1;
      if (bus.complete) begin
        lat = k;
        break;
      end
    end
    got = bus.dout;
    check($sformatf("txn%0d latency", txn), 128'(lat), 128'(LATENCY));
    @(posedge clk); #1;
    check($sformatf("txn%0d single_pulse", txn), 128'(bus.complete), 128'd0);
    check($sformatf("txn%0d idle_busy", txn), 128'(bus.busy), 128'd0);
    $display("txn %0d re=%0b we=%0b addr=%0d off=%0d din=%h dout=%h lat=%0d",
             txn, r, w, a, o, d, got, lat);
    txn++;
  endtask

  initial begin
    logic [127:0]      got;
    logic [127:0]      exp;
    logic [ADDR_W-1:0] a;
    logic [ADDR_W-1:0] b;
    logic [1:0]        o;
    logic [31:0]       d;
    logic              r;
    logic              w;
    int                kind;
    int                pulses;

    clk = 1'b0; rst = 1'b0;
    bus.re = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.offset = 2'd0; bus.din = 32'd0;
    foreach (mdl[i]) mdl[i] = 128'd0;

    // Asynchronous reset asserted mid-cycle must clear outputs before any edge.
    #12 rst = 1'b1;
    #1;
    check("reset_complete", 128'(bus.complete), 128'd0);
    check("reset_busy", 128'(bus.busy), 128'd0);
    check("reset_dout", bus.dout, 128'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    vecs[0]  = '{re:1'b0, we:1'b1, addr:5, off:2'd0, din:32'h0,        exp_dout:128'h0};
    vecs[1]  = '{re:1'b0, we:1'b1, addr:5, off:2'd1, din:32'h0,        exp_dout:128'h0};
    vecs[2]  = '{re:1'b0, we:1'b1, addr:5, off:2'd3, din:32'h0,        exp_dout:128'h0};
    vecs[3]  = '{re:1'b0, we:1'b1, addr:5, off:2'd2, din:32'hDEADBEEF, exp_dout:128'h0};
    vecs[4]  = '{re:1'b1, we:1'b0, addr:5, off:2'd0, din:32'h0,
                 exp_dout:128'h00000000_DEADBEEF_00000000_00000000};
    vecs[5]  = '{re:1'b0, we:1'b1, addr:0, off:2'd0, din:32'h11111111,
                 exp_dout:128'h00000000_DEADBEEF_00000000_00000000};
    vecs[6]  = '{re:1'b0, we:1'b1, addr:0, off:2'd1, din:32'h22222222,
                 exp_dout:128'h00000000_DEADBEEF_00000000_00000000};
    vecs[7]  = '{re:1'b0, we:1'b1, addr:0, off:2'd2, din:32'h33333333,
                 exp_dout:128'h00000000_DEADBEEF_00000000_00000000};
    vecs[8]  = '{re:1'b0, we:1'b1, addr:0, off:2'd3, din:32'h44444444,
                 exp_dout:128'h00000000_DEADBEEF_00000000_00000000};
    vecs[9]  = '{re:1'b1, we:1'b0, addr:0, off:2'd0, din:32'h0,
                 exp_dout:128'h44444444_33333333_22222222_11111111};
    vecs[10] = '{re:1'b0, we:1'b1, addr:7, off:2'd0, din:32'h0,
                 exp_dout:128'h44444444_33333333_22222222_11111111};
    vecs[11] = '{re:1'b0, we:1'b1, addr:7, off:2'd1, din:32'h0,
                 exp_dout:128'h44444444_33333333_22222222_11111111};
    vecs[12] = '{re:1'b0, we:1'b1, addr:7, off:2'd2, din:32'h0,
                 exp_dout:128'h44444444_33333333_22222222_11111111};
    vecs[13] = '{re:1'b0, we:1'b1, addr:7, off:2'd3, din:32'h0,
                 exp_dout:128'h44444444_33333333_22222222_11111111};
    vecs[14] = '{re:1'b1, we:1'b1, addr:7, off:2'd1, din:32'hCAFE0001,
                 exp_dout:128'h00000000_00000000_CAFE0001_00000000};

    for (int i = 0; i < 15; i++) begin
      access(vecs[i].re, vecs[i].we, vecs[i].addr, vecs[i].off, vecs[i].din, got);
      check($sformatf("vec%0d dout", i), got, vecs[i].exp_dout);
    end
    last_dout = vecs[14].exp_dout;

    // Define every word of the random-phase addresses so reads are predictable.
    foreach (addr_set[i]) begin
      for (int k = 0; k < 4; k++) begin
        a = ADDR_W'(addr_set[i]); o = 2'(k); d = $urandom;
        mdl[a][32*k +: 32] = d;
        access(1'b0, 1'b1, a, o, d, got);
        check($sformatf("init a%0d o%0d dout", a, k), got, last_dout);
      end
    end

    for (int i = 0; i < 120; i++) begin
      a = ADDR_W'(addr_set[$urandom_range(0, 7)]);
      o = 2'($urandom_range(0, 3));
      d = $urandom;
      kind = $urandom_range(0, 2);
      r = (kind != 1);
      w = (kind != 0);
      if (w) mdl[a][32*int'(o) +: 32] = d;
      exp = r ? mdl[a] : last_dout;
      access(r, w, a, o, d, got);
      check($sformatf("rand%0d dout", i), got, exp);
      last_dout = exp;
    end

    // Requests and address changes while busy must not disturb the latched access.
    a = ADDR_W'(addr_set[2]);
    @(negedge clk);
    bus.re = 1'b1; bus.we = 1'b0; bus.addr = a;
    @(posedge clk);
    pulses = 0;
    for (int k = 0; k < LATENCY + 10; k++) begin
      @(negedge clk);
      if (k < LATENCY - 2) begin
        b = ADDR_W'(addr_set[$urandom_range(3, 7)]);
        bus.re = 1'($urandom_range(0, 1));
        bus.we = 1'b0;
        bus.addr = b;
      end else begin
        bus.re = 1'b0;
      end
      if (bus.complete) pulses++;
    end
    check("ignored_pulses", 128'(pulses), 128'd1);
    check("ignored_dout", bus.dout, mdl[a]);
    $display("txn %0d ignored-request sequence addr=%0d pulses=%0d dout=%h", txn, a, pulses, bus.dout);
    txn++;
    last_dout = mdl[a];

    // Reset in the middle of a write: write is dropped, outputs clear at once.
    @(negedge clk);
    bus.we = 1'b1; bus.re = 1'b0; bus.addr = 3; bus.offset = 2'd0; bus.din = 32'hFFFFFFFF;
    @(posedge clk); #1;
    bus.we = 1'b0;
    repeat (9) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_busy", 128'(bus.busy), 128'd0);
    check("midrst_complete", 128'(bus.complete), 128'd0);
    check("midrst_dout", bus.dout, 128'd0);
    @(negedge clk) rst = 1'b0;
    last_dout = 128'd0;
    pulses = 0;
    for (int k = 0; k < 2 * LATENCY; k++) begin
      @(negedge clk);
      if (bus.complete) pulses++;
    end
    check("midrst_no_pulse", 128'(pulses), 128'd0);
    $display("txn %0d reset-mid-write sequence pulses=%0d", txn, pulses);
    txn++;

    access(1'b1, 1'b0, 3, 2'd0, 32'h0, got);
    check("midrst_addr3_intact", got, mdl[3]);

    d = $urandom;
    mdl[TOP][96 +: 32] = d;
    access(1'b0, 1'b1, ADDR_W'(TOP), 2'd3, d, got);
    check("top_write_dout", got, mdl[3]);
    access(1'b1, 1'b0, ADDR_W'(TOP), 2'd0, 32'h0, got);
    check("top_read", got, mdl[TOP]);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
